ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-master AHB round-robin arbiter with burst tracking
// Optional locked-transfer support is enabled by defining ARB_LOCK_EN.
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic [1:0] hbusreq,
`ifdef ARB_LOCK_EN
  input  logic [1:0] hlock,
`endif
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  output logic [1:0] hgrant,
  output logic       hmaster,
  output logic       hmaster_d,
  output logic       hmastlock
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_INCR  = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic       DEF_M     = (DEFAULT_MASTER != 0);
  localparam logic [1:0] DEF_GRANT = DEF_M ? 2'b10 : 2'b01;

  state_t     state, next_state;
  logic [3:0] beat_cnt, next_cnt;
  logic       last_grant;
  logic       arb;
  logic       lock_hold;
  logic       any_req;
  logic       winner;

  function automatic logic [3:0] burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: burst_len = 4'd3;
      3'd4, 3'd5: burst_len = 4'd7;
      3'd6, 3'd7: burst_len = 4'd15;
      default:    burst_len = 4'd0;
    endcase
  endfunction

`ifdef ARB_LOCK_EN
  assign lock_hold = hlock[hmaster];
`else
  assign lock_hold = 1'b0;
`endif

  // Locked owner keeps the bus; otherwise the master not most recently granted wins ties.
  always_comb begin
    winner  = DEF_M;
    any_req = 1'b1;
    if (lock_hold) begin
      winner = hmaster;
    end else begin
      case (hbusreq)
        2'b01:   winner = 1'b0;
        2'b10:   winner = 1'b1;
        2'b11:   winner = ~last_grant;
        default: begin
          winner  = DEF_M;
          any_req = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = beat_cnt;
    arb        = 1'b0;
    case (state)
      ST_IDLE: arb = 1'b1;
      ST_OWN, ST_INCR: begin
        if (state == ST_INCR && !hbusreq[hmaster]) begin
          arb = 1'b1;
        end else if (state == ST_OWN && htrans == TR_IDLE) begin
          arb = 1'b1;
        end else if (htrans == TR_NONSEQ) begin
          if (hburst == 3'd0) begin
            arb = 1'b1;
          end else if (hburst == 3'd1) begin
            next_state = ST_INCR;
          end else begin
            next_cnt   = burst_len(hburst);
            next_state = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        case (htrans)
          TR_IDLE: arb = 1'b1;
          TR_BUSY: next_cnt = beat_cnt;
          TR_NONSEQ: begin
            if (hburst == 3'd0) begin
              arb = 1'b1;
            end else if (hburst == 3'd1) begin
              next_state = ST_INCR;
            end else begin
              next_cnt = burst_len(hburst);
            end
          end
          TR_SEQ: begin
            // Saturating decrement; a SEQ at zero is illegal but must not wedge the bus.
            next_cnt = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
            if (beat_cnt <= 4'd1) begin
              arb = 1'b1;
            end
          end
          default: next_cnt = beat_cnt;
        endcase
      end
      default: next_state = ST_IDLE;
    endcase
    if (arb) begin
      next_state = any_req ? ST_OWN : ST_IDLE;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      beat_cnt   <= 4'd0;
      hgrant     <= DEF_GRANT;
      hmaster    <= DEF_M;
      hmaster_d  <= DEF_M;
      last_grant <= DEF_M;
    end else if (hready) begin
      state     <= next_state;
      beat_cnt  <= next_cnt;
      hmaster_d <= hmaster;
      if (arb) begin
        hgrant  <= winner ? 2'b10 : 2'b01;
        hmaster <= winner;
        if (any_req) begin
          last_grant <= winner;
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hmastlock <= 1'b0;
    end else if (hready) begin
      hmastlock <= hlock[hmaster];
    end
  end
`else
  assign hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter
// Covers the ARB_LOCK_EN scenario when the macro is defined.
module tb_ahb_arbiter;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [1:0] hbusreq;
`ifdef ARB_LOCK_EN
  logic [1:0] hlock;
`endif
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hgrant;
  logic       hmaster;
  logic       hmaster_d;
  logic       hmastlock;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.DEFAULT_MASTER(0)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
`ifdef ARB_LOCK_EN
    .hlock     (hlock),
`endif
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  typedef struct packed {
    logic [1:0] grant;
    logic       master;
    logic       master_d;
    logic       mastlock;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, compare after the edge.
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic [1:0] eg,
                      input logic em, input logic emd, input logic eml);
    exp_t e;
    hbusreq = req;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    e.grant    = eg;
    e.master   = em;
    e.master_d = emd;
    e.mastlock = eml;
    exp_q.push_back(e);
    @(posedge hclk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".grant"}, 32'(hgrant), 32'(e.grant));
      check({tag, ".master"}, 32'(hmaster), 32'(e.master));
      check({tag, ".master_d"}, 32'(hmaster_d), 32'(e.master_d));
      check({tag, ".mastlock"}, 32'(hmastlock), 32'(e.mastlock));
    end
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    hbusreq = 2'b00;
    htrans  = T_IDLE;
    hburst  = 3'd0;
    hready  = 1'b1;
`ifdef ARB_LOCK_EN
    hlock   = 2'b00;
`endif
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst.grant", 32'(hgrant), 32'h1);
    check("rst.master", 32'(hmaster), 32'h0);
    check("rst.master_d", 32'(hmaster_d), 32'h0);
    check("rst.mastlock", 32'(hmastlock), 32'h0);
    check("rst.cnt", 32'(dut.beat_cnt), 32'h0);

    // Park with no requests
    for (int i = 0; i < 3; i++) step("park", 2'b00, T_IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    check("park.state", 32'(dut.state), 32'h0);

    // Both masters issuing SINGLE transfers alternate
    step("rr1", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("rr2", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    step("rr3", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("rr4", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);

    // Master0 INCR4 with a BUSY and a two-cycle stall
    do_reset();
    step("b4.own", 2'b01, T_IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b4.ns", 2'b11, T_NSEQ, 3'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    check("b4.cnt_load", 32'(dut.beat_cnt), 32'd3);
    step("b4.s1", 2'b11, T_SEQ, 3'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b4.busy", 2'b11, T_BUSY, 3'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    check("b4.cnt_busy", 32'(dut.beat_cnt), 32'd2);
    step("b4.st1", 2'b11, T_SEQ, 3'd3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b4.st2", 2'b11, T_SEQ, 3'd3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    check("b4.cnt_stall", 32'(dut.beat_cnt), 32'd2);
    step("b4.s2", 2'b11, T_SEQ, 3'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("b4.s3", 2'b11, T_SEQ, 3'd3, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    check("b4.cnt_end", 32'(dut.beat_cnt), 32'd0);
    step("b4.next", 2'b11, T_IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);

    // Master1 INCR8 terminated early with IDLE
    do_reset();
    step("b8.own", 2'b10, T_IDLE, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("b8.ns", 2'b01, T_NSEQ, 3'd5, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    check("b8.cnt_load", 32'(dut.beat_cnt), 32'd7);
    step("b8.s1", 2'b01, T_SEQ, 3'd5, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    step("b8.s2", 2'b01, T_SEQ, 3'd5, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    step("b8.stall", 2'b01, T_IDLE, 3'd5, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    step("b8.term", 2'b01, T_IDLE, 3'd5, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);

    // INCR (undefined length) holds while the owner requests
    do_reset();
    step("inc.own", 2'b01, T_IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("inc.ns", 2'b11, T_NSEQ, 3'd1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("inc.s1", 2'b11, T_SEQ, 3'd1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("inc.rel", 2'b10, T_SEQ, 3'd1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);

    // Reset during beat 5 of an INCR16 owned by master1, with hready low
    do_reset();
    step("b16.own", 2'b10, T_IDLE, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("b16.ns", 2'b10, T_NSEQ, 3'd7, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("b16.seq", 2'b10, T_SEQ, 3'd7, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    check("b16.cnt_mid", 32'(dut.beat_cnt), 32'd12);
    hreset = 1'b1;
    step("b16.rst", 2'b11, T_SEQ, 3'd7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    hreset = 1'b0;
    check("b16.cnt_rst", 32'(dut.beat_cnt), 32'd0);
    check("b16.state_rst", 32'(dut.state), 32'd0);

`ifdef ARB_LOCK_EN
    // Master1 keeps the bus while locked, releases when the lock drops
    do_reset();
    hlock = 2'b10;
    step("lk.arb", 2'b11, T_IDLE, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step("lk.s1", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
    step("lk.s2", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
    hlock = 2'b00;
    step("lk.rel", 2'b11, T_NSEQ, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
